hv_cosine_stream: RTL and testbench

//  Streaming integer cosine-similarity engine for hypervectors (MNIST class matching), successor to the fixed-N FP core.

---
 rtl/hv_cosine_stream.sv | 267 ++++++++++++++++++++++++++
 tb/tb_hv_cosine_stream.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_cosine_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hv_cosine_stream                                              |
// | Brief    : streaming exact dot(A,B), sum(A^2), sum(B^2) per hypervector; |
// |            define HVCOS_RATIO_EN to add a serial cos*|cos| divider.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module hv_cosine_stream #(
  parameter  int W     = 8,
  parameter  int LANES = 4,
  parameter  int DIM   = 1024,
  parameter  int FRAC  = 16,
  localparam int BEATS = DIM / LANES,
  localparam int ACC_W = 2*W + $clog2(DIM) + 1
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [W*LANES-1:0] s_a,
  input  logic [W*LANES-1:0] s_b,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [ACC_W-1:0]   m_dot,
  output logic [ACC_W-1:0]   m_sqa,
  output logic [ACC_W-1:0]   m_sqb,
  output logic               m_err
`ifdef HVCOS_RATIO_EN
  ,
  output logic [FRAC+1:0]    m_score
`endif
);

  localparam int c_bc_w = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [c_bc_w-1:0] c_last_beat = c_bc_w'(BEATS - 1);

  generate
    if (((DIM % LANES) != 0) || (FRAC < 1)) begin : g_bad_cfg
      $error("hv_cosine_stream: DIM must be a multiple of LANES and FRAC >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RATIO = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_bc_w-1:0]   r_beat_cnt;
  logic [1:0]          r_drain_cnt;
  logic                r_err;
  logic                r_s_ready;
  logic                r_m_valid;
  logic [ACC_W-1:0]    r_m_dot;
  logic [ACC_W-1:0]    r_m_sqa;
  logic [ACC_W-1:0]    r_m_sqb;
  logic                r_m_err;

  logic signed [W-1:0]     w_a    [LANES];
  logic signed [W-1:0]     w_b    [LANES];
  logic signed [2*W-1:0]   r_p_ab [LANES];
  logic signed [2*W-1:0]   r_p_aa [LANES];
  logic signed [2*W-1:0]   r_p_bb [LANES];
  logic                    r_v1;
  logic                    r_v2;
  logic signed [ACC_W-1:0] w_sum_ab, w_sum_aa, w_sum_bb;
  logic signed [ACC_W-1:0] r_t_ab, r_t_aa, r_t_bb;
  logic signed [ACC_W-1:0] r_acc_dot, r_acc_sqa, r_acc_sqb;

  logic w_take;
  logic w_accept;

  assign w_take   = s_valid && r_s_ready;
  assign w_accept = r_m_valid && m_ready;

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_dot   = r_m_dot;
  assign m_sqa   = r_m_sqa;
  assign m_sqb   = r_m_sqb;
  assign m_err   = r_m_err;

  // Lane products are sign-extended to the accumulator width before summing.
  always_comb begin
    w_sum_ab = '0;
    w_sum_aa = '0;
    w_sum_bb = '0;
    for (int i = 0; i < LANES; i++) begin
      w_a[i]   = s_a[W*i +: W];
      w_b[i]   = s_b[W*i +: W];
      w_sum_ab = w_sum_ab + {{(ACC_W-2*W){r_p_ab[i][2*W-1]}}, r_p_ab[i]};
      w_sum_aa = w_sum_aa + {{(ACC_W-2*W){r_p_aa[i][2*W-1]}}, r_p_aa[i]};
      w_sum_bb = w_sum_bb + {{(ACC_W-2*W){r_p_bb[i][2*W-1]}}, r_p_bb[i]};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_p_ab[i] <= '0;
        r_p_aa[i] <= '0;
        r_p_bb[i] <= '0;
      end
      r_t_ab    <= '0;
      r_t_aa    <= '0;
      r_t_bb    <= '0;
      r_acc_dot <= '0;
      r_acc_sqa <= '0;
      r_acc_sqb <= '0;
    end else begin
      r_v1 <= w_take;
      if (w_take) begin
        for (int i = 0; i < LANES; i++) begin
          r_p_ab[i] <= (2*W)'(w_a[i]) * (2*W)'(w_b[i]);
          r_p_aa[i] <= (2*W)'(w_a[i]) * (2*W)'(w_a[i]);
          r_p_bb[i] <= (2*W)'(w_b[i]) * (2*W)'(w_b[i]);
        end
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_t_ab <= w_sum_ab;
        r_t_aa <= w_sum_aa;
        r_t_bb <= w_sum_bb;
      end
      if (w_accept) begin
        r_acc_dot <= '0;
        r_acc_sqa <= '0;
        r_acc_sqb <= '0;
      end else if (r_v2) begin
        r_acc_dot <= r_acc_dot + r_t_ab;
        r_acc_sqa <= r_acc_sqa + r_t_aa;
        r_acc_sqb <= r_acc_sqb + r_t_bb;
      end
    end
  end

`ifdef HVCOS_RATIO_EN
  localparam int c_pw   = 2*ACC_W + FRAC + 1;
  localparam int c_dv_w = $clog2(FRAC + 2);
  localparam logic [c_dv_w-1:0] c_div_last = c_dv_w'(FRAC + 1);
  localparam logic [FRAC:0]     c_one      = {1'b1, {FRAC{1'b0}}};

  logic [ACC_W-1:0]   w_mag;
  logic [2*ACC_W-1:0] w_num_sq;
  logic [2*ACC_W-1:0] w_den;
  logic [FRAC:0]      w_qsat;
  logic [FRAC+1:0]    w_score;
  logic [c_pw-1:0]    r_rem;
  logic [c_pw-1:0]    r_den;
  logic [FRAC:0]      r_q;
  logic               r_neg;
  logic               r_zero;
  logic [c_dv_w-1:0]  r_div_cnt;
  logic [FRAC+1:0]    r_m_score;

  assign w_mag    = r_acc_dot[ACC_W-1] ? -r_acc_dot : r_acc_dot;
  assign w_num_sq = (2*ACC_W)'(w_mag) * (2*ACC_W)'(w_mag);
  assign w_den    = (2*ACC_W)'(r_acc_sqa) * (2*ACC_W)'(r_acc_sqb);
  // Cauchy-Schwarz keeps the quotient at or below one; the clamp is a backstop.
  assign w_qsat   = (r_q > c_one) ? c_one : r_q;
  assign w_score  = r_zero ? '0 : (r_neg ? -{1'b0, w_qsat} : {1'b0, w_qsat});
  assign m_score  = r_m_score;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_ACC;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_err       <= 1'b0;
      r_s_ready   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_dot     <= '0;
      r_m_sqa     <= '0;
      r_m_sqb     <= '0;
      r_m_err     <= 1'b0;
`ifdef HVCOS_RATIO_EN
      r_rem       <= '0;
      r_den       <= '0;
      r_q         <= '0;
      r_neg       <= 1'b0;
      r_zero      <= 1'b0;
      r_div_cnt   <= '0;
      r_m_score   <= '0;
`endif
    end else begin
      case (r_state)
        ST_ACC: begin
          r_s_ready <= 1'b1;
          if (w_take) begin
            if (s_last != (r_beat_cnt == c_last_beat)) begin
              r_err <= 1'b1;
            end
            if (r_beat_cnt == c_last_beat) begin
              r_beat_cnt  <= '0;
              r_drain_cnt <= '0;
              r_s_ready   <= 1'b0;
              r_state     <= ST_DRAIN;
            end else begin
              r_beat_cnt <= r_beat_cnt + c_bc_w'(1);
            end
          end
        end
        // Two pipeline flush cycles, then one edge to latch the settled sums.
        ST_DRAIN: begin
          r_drain_cnt <= r_drain_cnt + 2'd1;
          if (r_drain_cnt == 2'd2) begin
`ifdef HVCOS_RATIO_EN
            r_rem     <= {1'b0, w_num_sq, {FRAC{1'b0}}};
            r_den     <= {1'b0, w_den, {FRAC{1'b0}}};
            r_neg     <= r_acc_dot[ACC_W-1];
            r_zero    <= (w_den == '0);
            r_q       <= '0;
            r_div_cnt <= '0;
            r_state   <= ST_RATIO;
`else
            r_m_dot   <= r_acc_dot;
            r_m_sqa   <= r_acc_sqa;
            r_m_sqb   <= r_acc_sqb;
            r_m_err   <= r_err;
            r_m_valid <= 1'b1;
            r_state   <= ST_OUT;
`endif
          end
        end
`ifdef HVCOS_RATIO_EN
        ST_RATIO: begin
          if (r_div_cnt == c_div_last) begin
            r_m_dot   <= r_acc_dot;
            r_m_sqa   <= r_acc_sqa;
            r_m_sqb   <= r_acc_sqb;
            r_m_err   <= r_err;
            r_m_score <= w_score;
            r_m_valid <= 1'b1;
            r_state   <= ST_OUT;
          end else begin
            if (r_rem >= r_den) begin
              r_rem <= r_rem - r_den;
              r_q   <= {r_q[FRAC-1:0], 1'b1};
            end else begin
              r_q   <= {r_q[FRAC-1:0], 1'b0};
            end
            r_den     <= r_den >> 1;
            r_div_cnt <= r_div_cnt + c_dv_w'(1);
          end
        end
`endif
        ST_OUT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_err     <= 1'b0;
            r_s_ready <= 1'b1;
            r_state   <= ST_ACC;
          end
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hv_cosine_stream.sv
`default_nettype none
// Bench for hv_cosine_stream: directed vector table, handshake corner sequences,
// and randomized vectors checked against a plain-arithmetic cosine model.
module tb_hv_cosine_stream;
  localparam int W     = 8;
  localparam int LANES = 4;
  localparam int DIM   = 8;
  localparam int FRAC  = 16;
  localparam int BEATS = DIM / LANES;
  localparam int ACC_W = 2*W + $clog2(DIM) + 1;
`ifdef HVCOS_RATIO_EN
  localparam int LAT = FRAC + 5;
`else
  localparam int LAT = 3;
`endif

  typedef int elem_t [DIM];
  typedef struct {
    elem_t            a;
    elem_t            b;
    logic [BEATS-1:0] lastm;
    bit               gap;
    longint           dot;
    longint           sqa;
    longint           sqb;
    bit               err;
    longint           score;
  } vec_t;

  logic               aclk    = 1'b0;
  logic               aresetn = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_last  = 1'b0;
  logic               m_ready = 1'b0;
  logic [W*LANES-1:0] s_a     = '0;
  logic [W*LANES-1:0] s_b     = '0;
  logic               s_ready;
  logic               m_valid;
  logic               m_err;
  logic [ACC_W-1:0]   m_dot;
  logic [ACC_W-1:0]   m_sqa;
  logic [ACC_W-1:0]   m_sqb;
`ifdef HVCOS_RATIO_EN
  logic [FRAC+1:0]    m_score;
`endif

  int     n_total = 0;
  int     n_bad   = 0;
  longint cyc     = 0;
  longint last_k  = 0;

  hv_cosine_stream #(.W(W), .LANES(LANES), .DIM(DIM), .FRAC(FRAC)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_a     (s_a),
    .s_b     (s_b),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_dot   (m_dot),
    .m_sqa   (m_sqa),
    .m_sqb   (m_sqb),
    .m_err   (m_err)
`ifdef HVCOS_RATIO_EN
    ,
    .m_score (m_score)
`endif
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model(input elem_t a, input elem_t b, input logic [BEATS-1:0] lastm,
                       output longint dot, output longint sqa, output longint sqb,
                       output bit err, output longint score);
    longint q;
    dot = 0; sqa = 0; sqb = 0; err = 0;
    for (int i = 0; i < DIM; i++) begin
      dot += longint'(a[i]) * b[i];
      sqa += longint'(a[i]) * a[i];
      sqb += longint'(b[i]) * b[i];
    end
    for (int j = 0; j < BEATS; j++)
      if (lastm[j] != (j == BEATS-1)) err = 1;
    if (sqa == 0 || sqb == 0) score = 0;
    else begin
      q = (dot * dot * (longint'(1) << FRAC)) / (sqa * sqb);
      if (q > (longint'(1) << FRAC)) q = longint'(1) << FRAC;
      score = (dot < 0) ? -q : q;
    end
  endtask

  // Called at a falling edge; leaves the bench at a falling edge.
  task automatic send_vec(input elem_t a, input elem_t b, input logic [BEATS-1:0] lastm, input bit gap);
    for (int j = 0; j < BEATS; j++) begin
      int t = 0;
      for (int i = 0; i < LANES; i++) begin
        s_a[W*i +: W] = W'(a[j*LANES+i]);
        s_b[W*i +: W] = W'(b[j*LANES+i]);
      end
      s_last  = lastm[j];
      s_valid = 1'b1;
      while (!s_ready && t < 50) begin
        @(negedge aclk);
        t++;
      end
      if (!s_ready) chk("s_ready wait timeout", 0, 1);
      @(posedge aclk);
      @(negedge aclk);
      last_k  = cyc;
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (gap) @(negedge aclk);
    end
  endtask

  task automatic get_res(input string tag, input longint dot, input longint sqa, input longint sqb,
                         input bit err, input longint score, input int hold);
    int t = 0;
    logic [3*ACC_W:0] snap;
    bit same;
    while (!m_valid && t < 100) begin
      @(negedge aclk);
      t++;
    end
    if (!m_valid) begin
      chk({tag, " m_valid timeout"}, 0, 1);
      return;
    end
    chk({tag, " latency"}, cyc - last_k, LAT);
    chk({tag, " m_dot"}, longint'($signed(m_dot)), dot);
    chk({tag, " m_sqa"}, longint'($signed(m_sqa)), sqa);
    chk({tag, " m_sqb"}, longint'($signed(m_sqb)), sqb);
    chk({tag, " m_err"}, longint'(m_err), longint'(err));
`ifdef HVCOS_RATIO_EN
    chk({tag, " m_score"}, longint'($signed(m_score)), score);
`else
    if (score == 64'sd1) $display("note: score %0d not checked", score);
`endif
    snap = {m_dot, m_sqa, m_sqb, m_err};
    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      same = ({m_valid, s_ready, m_dot, m_sqa, m_sqb, m_err} == {1'b1, 1'b0, snap});
`ifdef HVCOS_RATIO_EN
      same = same && (longint'($signed(m_score)) == score);
`endif
      chk({tag, " held stable"}, longint'(same), 1);
    end
    m_ready = 1'b1;
    @(negedge aclk);
    m_ready = 1'b0;
    chk({tag, " m_valid dropped"}, longint'(m_valid), 0);
    chk({tag, " s_ready restored"}, longint'(s_ready), 1);
  endtask

  task automatic no_valid(input string tag, input int n);
    bit seen = 0;
    repeat (n) begin
      @(negedge aclk);
      if (m_valid) seen = 1;
    end
    chk(tag, longint'(seen), 0);
  endtask

  initial begin
    vec_t tbl [7];
    tbl[0].a = '{default:3};  tbl[0].b = '{default:3};  tbl[0].lastm = 2'b10; tbl[0].gap = 0;
    tbl[0].dot = 72;  tbl[0].sqa = 72; tbl[0].sqb = 72; tbl[0].err = 0; tbl[0].score = 65536;
    tbl[1].a = '{default:2};  tbl[1].b = '{default:-2}; tbl[1].lastm = 2'b10; tbl[1].gap = 0;
    tbl[1].dot = -32; tbl[1].sqa = 32; tbl[1].sqb = 32; tbl[1].err = 0; tbl[1].score = -65536;
    tbl[2].a = '{default:1};  tbl[2].b = '{1,-1,1,-1,1,-1,1,-1}; tbl[2].lastm = 2'b10; tbl[2].gap = 0;
    tbl[2].dot = 0;   tbl[2].sqa = 8;  tbl[2].sqb = 8;  tbl[2].err = 0; tbl[2].score = 0;
    tbl[3].a = '{default:0};  tbl[3].b = '{1,-1,1,-1,1,-1,1,-1}; tbl[3].lastm = 2'b10; tbl[3].gap = 0;
    tbl[3].dot = 0;   tbl[3].sqa = 0;  tbl[3].sqb = 8;  tbl[3].err = 0; tbl[3].score = 0;
    tbl[4].a = '{1,1,0,0,0,0,0,0}; tbl[4].b = '{1,0,0,0,0,0,0,0}; tbl[4].lastm = 2'b10; tbl[4].gap = 1;
    tbl[4].dot = 1;   tbl[4].sqa = 2;  tbl[4].sqb = 1;  tbl[4].err = 0; tbl[4].score = 32768;
    tbl[5].a = '{default:3};  tbl[5].b = '{default:3};  tbl[5].lastm = 2'b01; tbl[5].gap = 0;
    tbl[5].dot = 72;  tbl[5].sqa = 72; tbl[5].sqb = 72; tbl[5].err = 1; tbl[5].score = 65536;
    tbl[6].a = '{1,2,3,4,5,6,7,8}; tbl[6].b = '{default:1}; tbl[6].lastm = 2'b10; tbl[6].gap = 1;
    tbl[6].dot = 36;  tbl[6].sqa = 204; tbl[6].sqb = 8; tbl[6].err = 0; tbl[6].score = 52043;

    repeat (3) @(negedge aclk);
    chk("reset s_ready", longint'(s_ready), 0);
    chk("reset m_valid", longint'(m_valid), 0);
    chk("reset m_dot", longint'(m_dot), 0);
    chk("reset m_err", longint'(m_err), 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("s_ready after reset", longint'(s_ready), 1);

    for (int v = 0; v < 7; v++) begin
      send_vec(tbl[v].a, tbl[v].b, tbl[v].lastm, tbl[v].gap);
      get_res($sformatf("vec%0d", v), tbl[v].dot, tbl[v].sqa, tbl[v].sqb, tbl[v].err, tbl[v].score, 0);
    end

    // Backpressure: result held 6 cycles, then the next vector must be clean.
    send_vec(tbl[1].a, tbl[1].b, tbl[1].lastm, 0);
    get_res("hold6", tbl[1].dot, tbl[1].sqa, tbl[1].sqb, 0, tbl[1].score, 6);
    send_vec(tbl[0].a, tbl[0].b, tbl[0].lastm, 0);
    get_res("after hold", 72, 72, 72, 0, 65536, 0);

    // Reset after beat 0 with s_last asserted early.
    s_a = {LANES{8'd5}};
    s_b = {LANES{8'd7}};
    s_last  = 1'b1;
    s_valid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    chk("mid-vector reset s_ready", longint'(s_ready), 0);
    aresetn = 1'b1;
    no_valid("no m_valid after mid-vector reset", 40);
    send_vec(tbl[0].a, tbl[0].b, tbl[0].lastm, 0);
    get_res("clean after reset", 72, 72, 72, 0, 65536, 0);

    // Reset while the completed vector is still draining.
    send_vec(tbl[1].a, tbl[1].b, tbl[1].lastm, 0);
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    no_valid("no m_valid after drain reset", 40);
    send_vec(tbl[6].a, tbl[6].b, tbl[6].lastm, 0);
    get_res("clean after drain reset", 36, 204, 8, 0, 52043, 0);

    for (int r = 0; r < 24; r++) begin
      elem_t a, b;
      logic [BEATS-1:0] lm;
      longint d, qa, qb, sc;
      bit e, gap, pre;
      int hold;
      for (int i = 0; i < DIM; i++) begin
        a[i] = int'($urandom_range(0, 255)) - 128;
        b[i] = int'($urandom_range(0, 255)) - 128;
        if (r == 0) begin a[i] = -128; b[i] = -128; end
        if (r == 1) begin a[i] = -128; b[i] = 127; end
      end
      lm = '0;
      lm[BEATS-1] = 1'b1;
      if ($urandom_range(0, 3) == 0) lm = BEATS'($urandom_range(0, 3));
      gap  = 1'($urandom_range(0, 1));
      pre  = ($urandom_range(0, 3) == 0);
      hold = pre ? 0 : int'($urandom_range(0, 3));
      model(a, b, lm, d, qa, qb, e, sc);
      m_ready = pre;
      send_vec(a, b, lm, gap);
      get_res($sformatf("rand%0d", r), d, qa, qb, e, sc, hold);
      m_ready = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
